// File: rtl/load_store_unit.sv
// load_store_unit: sequences core loads/stores onto a single-ported data bus.
// It stalls the core until the bus acks or times out, returns extended load
// data, builds byte strobes and lane-replicated store data, and rejects
// misaligned accesses.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  mem_op_length,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        bus_error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state;
  logic [7:0]  count;
  logic [1:0]  lane;
  logic [2:0]  op;
  logic        err;

  logic        access;
  logic        aligned;
  logic [3:0]  strb_next;
  logic [31:0] wdata_next;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rdata_ext;

  // Decode the incoming access: alignment, strobes and replicated store data.
  always_comb begin
    access     = mem_read | mem_write;
    aligned    = 1'b1;
    strb_next  = 4'b1111;
    wdata_next = store_data;
    case (mem_op_length[1:0])
      MEM_BYTE: begin
        strb_next  = 4'b0001 << address[1:0];
        wdata_next = {4{store_data[7:0]}};
      end
      MEM_HALF: begin
        aligned    = ~address[0];
        strb_next  = 4'b0011 << address[1:0];
        wdata_next = {2{store_data[15:0]}};
      end
      default: aligned = (address[1:0] == 2'b00);
    endcase
  end

  // Pick the addressed lane out of the read word and extend it.
  always_comb begin
    case (lane)
      2'd0:    rd_byte = bus_rdata[7:0];
      2'd1:    rd_byte = bus_rdata[15:8];
      2'd2:    rd_byte = bus_rdata[23:16];
      default: rd_byte = bus_rdata[31:24];
    endcase
    rd_half = lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (op[1:0])
      MEM_BYTE: rdata_ext = {{24{rd_byte[7] & ~op[2]}}, rd_byte};
      MEM_HALF: rdata_ext = {{16{rd_half[15] & ~op[2]}}, rd_half};
      default:  rdata_ext = bus_rdata;
    endcase
  end

  // Core-facing handshakes, combinational from state and the current access.
  always_comb begin
    stall      = ((state == IDLE) && access && aligned) || (state == REQ);
    misaligned = (state == IDLE) && access && !aligned;
    load_valid = (state == DONE) && !bus_we && !err;
    bus_error  = (state == DONE) && err;
  end

  // Access sequencer: latch the access, wait for ack or timeout, then finish.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      lane      <= '0;
      op        <= '0;
      err       <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wstrb <= '0;
      bus_wdata <= '0;
      load_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access && aligned) begin
            bus_addr  <= {address[31:2], 2'b00};
            bus_we    <= mem_write;
            bus_wstrb <= mem_write ? strb_next : 4'b0000;
            bus_wdata <= mem_write ? wdata_next : '0;
            lane      <= address[1:0];
            op        <= mem_op_length;
            count     <= '0;
            err       <= 1'b0;
            bus_req   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (bus_ack) begin
            load_data <= rdata_ext;
            bus_req   <= 1'b0;
            state     <= DONE;
          end else if (count == LAST_WAIT) begin
            load_data <= '0;
            err       <= 1'b1;
            bus_req   <= 1'b0;
            state     <= DONE;
          end else begin
            count <= count + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed load/store scenarios with literal expectations,
// plus a transaction-level model compared against the DUT every cycle.
module tb_load_store_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_op_length;
  logic [31:0] address;
  logic [31:0] store_data;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misaligned;
  logic        bus_error;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_pass  = 0;
  int n_total = 0;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_op_length(mem_op_length), .address(address), .store_data(store_data),
    .stall(stall), .load_data(load_data), .load_valid(load_valid),
    .misaligned(misaligned), .bus_error(bus_error), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---- specification-level helpers ----
  function automatic int unsigned size_of(input logic [2:0] op);
    case (op[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_aligned(input logic [2:0] op, input logic [31:0] a);
    return (a % size_of(op)) == 0;
  endfunction

  function automatic logic [3:0] strobe(input logic [2:0] op, input logic [31:0] a);
    int unsigned sz = size_of(op);
    int unsigned m;
    m = ((1 << sz) - 1) << ((sz == 4) ? 0 : (a % 4));
    return m[3:0];
  endfunction

  function automatic logic [31:0] repl(input logic [2:0] op, input logic [31:0] sd);
    int unsigned sz = size_of(op);
    if (sz == 1) return (sd & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] rd);
    int unsigned sz = size_of(op);
    logic [31:0] mask;
    logic [31:0] v;
    if (sz == 4) return rd;
    mask = (32'd1 << (8 * sz)) - 32'd1;
    v = (rd >> (8 * (a % 4))) & mask;
    if (!op[2] && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  // ---- per-cycle model and compare ----
  initial begin
    bit          known;
    int          phase;   // 0: waiting for access, 1: on the bus, 2: finishing
    int          waited;
    logic        m_we;
    logic        m_err;
    logic [2:0]  m_op;
    logic [31:0] m_a;
    logic [31:0] m_addr;
    logic [3:0]  m_strb;
    logic [31:0] m_wdata;
    logic [31:0] m_ld;
    bit          acc;
    bit          al;
    int          n_hi;
    known = 0; phase = 0; waited = 0; m_we = 0; m_err = 0; m_op = '0;
    m_a = '0; m_addr = '0; m_strb = '0; m_wdata = '0; m_ld = '0;
    forever begin
      @(negedge clk);
      acc = mem_read | mem_write;
      al  = is_aligned(mem_op_length, address);
      if (known) begin
        check("m_stall", {31'b0, stall},
              {31'b0, (phase == 1) || (phase == 0 && acc && al)});
        check("m_misaligned", {31'b0, misaligned}, {31'b0, phase == 0 && acc && !al});
        check("m_load_valid", {31'b0, load_valid}, {31'b0, phase == 2 && !m_we && !m_err});
        check("m_bus_error", {31'b0, bus_error}, {31'b0, phase == 2 && m_err});
        check("m_bus_req", {31'b0, bus_req}, {31'b0, phase == 1});
        if (phase == 1) begin
          check("m_bus_addr", bus_addr, m_addr);
          check("m_bus_we", {31'b0, bus_we}, {31'b0, m_we});
          check("m_bus_wstrb", {28'b0, bus_wstrb}, {28'b0, m_strb});
          if (m_we) check("m_bus_wdata", bus_wdata, m_wdata);
        end
        if (phase == 2) check("m_load_data", load_data, m_ld);
        n_hi = int'(stall) + int'(misaligned) + int'(load_valid) + int'(bus_error);
        check("m_exclusive", {31'b0, n_hi <= 1}, 32'd1);
      end
      if (reset) begin
        known = 1;
        phase = 0;
      end else if (known) begin
        case (phase)
          0: if (acc && al) begin
            phase   = 1;
            waited  = 0;
            m_we    = mem_write;
            m_op    = mem_op_length;
            m_a     = address;
            m_addr  = address - (address % 4);
            m_strb  = mem_write ? strobe(mem_op_length, address) : 4'b0000;
            m_wdata = repl(mem_op_length, store_data);
          end
          1: begin
            waited++;
            if (bus_ack) begin
              phase = 2;
              m_err = 0;
              m_ld  = extract(m_op, m_a, bus_rdata);
            end else if (waited == int'(TO)) begin
              phase = 2;
              m_err = 1;
              m_ld  = '0;
            end
          end
          default: phase = 0;
        endcase
      end
    end
  end

  // ---- directed stimulus ----
  int          r_stall, r_req;
  bit          r_mis, r_lv, r_err;
  logic [31:0] r_ld, r_addr, r_wdata;
  logic        r_we;
  logic [3:0]  r_strb;

  // Present one access, ack it k cycles later (k<0: never), record what was seen.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] sd,
                            input int k, input logic [31:0] rdata);
    bit fin = 0;
    mem_read = rd; mem_write = wr; mem_op_length = op; address = a; store_data = sd;
    r_stall = 0; r_req = 0; r_mis = 0; r_lv = 0; r_err = 0;
    r_ld = '0; r_addr = '0; r_wdata = '0; r_we = 0; r_strb = '0;
    for (int c = 0; c < 300 && !fin; c++) begin
      bus_ack   = (c == k);
      bus_rdata = (c == k) ? rdata : 32'h5A5A_A5A5;
      @(negedge clk);
      if (stall) r_stall++;
      if (bus_req) begin
        r_req++;
        if (r_req == 1) begin
          r_addr = bus_addr; r_we = bus_we; r_strb = bus_wstrb; r_wdata = bus_wdata;
        end
      end
      if (misaligned) r_mis = 1;
      if (load_valid) begin r_lv = 1; r_ld = load_data; end
      if (bus_error) begin r_err = 1; r_ld = load_data; end
      if (!stall) fin = 1;
      else begin @(posedge clk); #1; end
    end
    if (!fin) check("access_budget", {31'b0, stall}, 32'd0);
    mem_read = 0; mem_write = 0; bus_ack = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1; mem_read = 0; mem_write = 0; mem_op_length = '0; address = '0;
    store_data = '0; bus_ack = 0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("rst_bus_req", {31'b0, bus_req}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wstrb", {28'b0, bus_wstrb}, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    @(posedge clk); #1;

    // lw 0x10, ack on the third bus cycle
    run_access(1, 0, 3'b010, 32'h10, 32'h0, 3, 32'hDEAD_BEEF);
    check("lw_stall_cycles", r_stall, 32'd4);
    check("lw_bus_addr", r_addr, 32'h10);
    check("lw_wstrb", {28'b0, r_strb}, 32'd0);
    check("lw_valid", {31'b0, r_lv}, 32'd1);
    check("lw_data", r_ld, 32'hDEAD_BEEF);

    // lb / lbu at 0x13
    run_access(1, 0, 3'b000, 32'h13, 32'h0, 1, 32'h80FF_0000);
    check("lb_data", r_ld, 32'hFFFF_FF80);
    check("lb_bus_addr", r_addr, 32'h10);
    run_access(1, 0, 3'b100, 32'h13, 32'h0, 1, 32'h80FF_0000);
    check("lbu_data", r_ld, 32'h0000_0080);

    // lh / lhu at 0x12
    run_access(1, 0, 3'b001, 32'h12, 32'h0, 2, 32'h80FF_0000);
    check("lh_data", r_ld, 32'hFFFF_80FF);
    run_access(1, 0, 3'b101, 32'h12, 32'h0, 2, 32'h80FF_0000);
    check("lhu_data", r_ld, 32'h0000_80FF);

    // sh at 0x22
    run_access(0, 1, 3'b001, 32'h22, 32'h1234_ABCD, 2, 32'h0);
    check("sh_bus_addr", r_addr, 32'h20);
    check("sh_wstrb", {28'b0, r_strb}, 32'h0000_000C);
    check("sh_wdata", r_wdata, 32'hABCD_ABCD);
    check("sh_we", {31'b0, r_we}, 32'd1);
    check("sh_no_load_valid", {31'b0, r_lv}, 32'd0);

    // misaligned lw at 0x06 and sh at 0x03
    run_access(1, 0, 3'b010, 32'h06, 32'h0, -1, 32'h0);
    check("mis_lw_pulse", {31'b0, r_mis}, 32'd1);
    check("mis_lw_stall", r_stall, 32'd0);
    check("mis_lw_req", r_req, 32'd0);
    run_access(0, 1, 3'b001, 32'h03, 32'h0, -1, 32'h0);
    check("mis_sh_pulse", {31'b0, r_mis}, 32'd1);
    check("mis_sh_req", r_req, 32'd0);

    // timeout: no ack
    run_access(1, 0, 3'b010, 32'h04, 32'h0, -1, 32'h0);
    check("to_req_cycles", r_req, TO);
    check("to_error", {31'b0, r_err}, 32'd1);
    check("to_load_data", r_ld, 32'd0);
    check("to_no_valid", {31'b0, r_lv}, 32'd0);

    // ack on the final bus cycle before timeout still wins
    run_access(1, 0, 3'b010, 32'h08, 32'h0, int'(TO), 32'h1122_3344);
    check("lastack_valid", {31'b0, r_lv}, 32'd1);
    check("lastack_error", {31'b0, r_err}, 32'd0);
    check("lastack_data", r_ld, 32'h1122_3344);

    // read and write both high: store byte at 0x41
    run_access(1, 1, 3'b000, 32'h41, 32'h0000_005A, 1, 32'hFFFF_FFFF);
    check("rw_we", {31'b0, r_we}, 32'd1);
    check("rw_wstrb", {28'b0, r_strb}, 32'h0000_0002);
    check("rw_wdata", r_wdata, 32'h5A5A_5A5A);
    check("rw_no_valid", {31'b0, r_lv}, 32'd0);

    // reset during REQ, then a stray ack
    mem_read = 1; mem_op_length = 3'b010; address = 32'h30;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1; mem_read = 0;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    check("rreq_bus_req", {31'b0, bus_req}, 32'd0);
    check("rreq_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    bus_ack = 1; bus_rdata = 32'h7777_7777;
    @(negedge clk);
    check("stray_valid", {31'b0, load_valid}, 32'd0);
    check("stray_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    bus_ack = 0;
    @(negedge clk);
    check("stray_after_valid", {31'b0, load_valid}, 32'd0);
    check("stray_after_req", {31'b0, bus_req}, 32'd0);
    @(posedge clk); #1;

    // sw at 0x40 completes normally
    run_access(0, 1, 3'b010, 32'h40, 32'hCAFE_F00D, 1, 32'h0);
    check("sw_bus_addr", r_addr, 32'h40);
    check("sw_wstrb", {28'b0, r_strb}, 32'h0000_000F);
    check("sw_wdata", r_wdata, 32'hCAFE_F00D);
    check("sw_stall_cycles", r_stall, 32'd2);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
